// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants, configuration snapshot type and anode helper for the
// eight-digit seven-segment scan controller.
package seg7_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef struct packed {
    logic [8*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic [NUM_DIGITS-1:0]   blink_en;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RESET = '{
    data:     {(8*NUM_DIGITS){1'b1}},
    dig_en:   {NUM_DIGITS{1'b0}},
    blink_en: {NUM_DIGITS{1'b0}}
  };

  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load/acknowledge handshake between a display producer and the scan controller.
interface seg7_scan_ctrl_if;

  logic        load;
  logic [63:0] disp_data;
  logic [7:0]  dig_en;
  logic [7:0]  blink_en;
  logic        pending;
  logic        load_ack;

  modport master (
    output load, disp_data, dig_en, blink_en,
    input  pending, load_ack
  );

  modport slave (
    input  load, disp_data, dig_en, blink_en,
    output pending, load_ack
  );

endinterface

// File: rtl/MUX8T1_8.sv
// 8-bit wide 8:1 multiplexer, select s picks input I<s>.
module MUX8T1_8 (
  input  logic [2:0] s,
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [7:0] I3,
  input  logic [7:0] I4,
  input  logic [7:0] I5,
  input  logic [7:0] I6,
  input  logic [7:0] I7,
  output logic [7:0] o
);

  always_comb begin
    o = I0;
    case (s)
      3'd0: o = I0;
      3'd1: o = I1;
      3'd2: o = I2;
      3'd3: o = I3;
      3'd4: o = I4;
      3'd5: o = I5;
      3'd6: o = I6;
      3'd7: o = I7;
      default: o = I0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display with
// frame-synchronous snapshot commit, digit enable, blink and inter-digit blanking.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLINK_DIV = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_ctrl_if.slave     bus,
  output logic [IDX_W-1:0]    digit_idx,
  output logic [7:0]          an_n,
  output logic [7:0]          seg_n
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  disp_cfg_t        stage_q, stage_d;
  disp_cfg_t        active_q, active_d;
  logic             pending_q, pending_d;
  logic             ack_q, ack_d;
  logic             tick_dly_q, tick_dly_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic             tick;
  logic             frame_end;
  logic             commit;
  logic             visible;
  logic [7:0]       mux_o;

  MUX8T1_8 u_mux (
    .s  (idx_q),
    .I0 (active_q.data[7:0]),
    .I1 (active_q.data[15:8]),
    .I2 (active_q.data[23:16]),
    .I3 (active_q.data[31:24]),
    .I4 (active_q.data[39:32]),
    .I5 (active_q.data[47:40]),
    .I6 (active_q.data[55:48]),
    .I7 (active_q.data[63:56]),
    .o  (mux_o)
  );

  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    stage_d       = stage_q;
    active_d      = active_q;
    pending_d     = pending_q;
    ack_d         = 1'b0;
    tick_dly_d    = 1'b0;
    an_d          = an_q;
    seg_d         = seg_q;

    tick      = (presc_q == PRE_MAX);
    frame_end = tick && (idx_q == IDX_LAST);
    commit    = frame_end && pending_q;
    visible   = active_q.dig_en[idx_q] & ~(active_q.blink_en[idx_q] & blink_phase_q);

    presc_d    = tick ? '0 : presc_q + PRE_W'(1);
    tick_dly_d = tick;
    if (tick) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (frame_end) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    // Commit consumes the staging contents from before this edge, so a load
    // arriving in the commit cycle simply refills staging for the next frame.
    if (commit) begin
      active_d  = stage_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
    if (bus.load) begin
      stage_d.data     = bus.disp_data;
      stage_d.dig_en   = bus.dig_en;
      stage_d.blink_en = bus.blink_en;
      pending_d        = 1'b1;
    end

    // Blank for one cycle on each tick so the old segments never ghost onto
    // the next anode; the new digit is latched the cycle after.
    if (tick) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end else if (tick_dly_q) begin
      if (visible) begin
        an_d  = anode_sel(idx_q);
        seg_d = mux_o;
      end else begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      stage_q       <= CFG_RESET;
      active_q      <= CFG_RESET;
      pending_q     <= 1'b0;
      ack_q         <= 1'b0;
      tick_dly_q    <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      stage_q       <= stage_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      ack_q         <= ack_d;
      tick_dly_q    <= tick_dly_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign digit_idx    = idx_q;
  assign an_n         = an_q;
  assign seg_n        = seg_q;
  assign bus.pending  = pending_q;
  assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random loads, checked every
// cycle against a time-based reference model of the scan schedule.
module tb_seg7_scan_ctrl;

  localparam int TD = 4;
  localparam int BD = 2;
  localparam int FR = TD * 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] digit_idx;
  logic [7:0] an_n;
  logic [7:0] seg_n;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .digit_idx (digit_idx),
    .an_n      (an_n),
    .seg_n     (seg_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  // Reference model: n counts clock edges since reset release; everything in
  // the scan schedule is derived arithmetically from it.
  int          n = 0;
  logic [63:0] m_stage_data, m_act_data;
  logic [7:0]  m_stage_en, m_act_en, m_stage_bl, m_act_bl;
  bit          m_pend, m_ack;

  task automatic model_reset();
    n = 0;
    m_pend = 0;
    m_ack = 0;
    m_stage_data = '1; m_act_data = '1;
    m_stage_en = '0;   m_act_en = '0;
    m_stage_bl = '0;   m_act_bl = '0;
  endtask

  task automatic model_edge();
    bit boundary;
    n++;
    boundary = (n % FR) == 0;
    m_ack = boundary && m_pend;
    if (m_ack) begin
      m_act_data = m_stage_data;
      m_act_en   = m_stage_en;
      m_act_bl   = m_stage_bl;
      m_pend     = 0;
    end
    if (bus.load) begin
      m_stage_data = bus.disp_data;
      m_stage_en   = bus.dig_en;
      m_stage_bl   = bus.blink_en;
      m_pend       = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int s, p, idx;
    bit ph, vis;
    logic [7:0] e_an, e_seg;
    s = n / TD;
    p = n % TD;
    idx = s % 8;
    ph = ((n / FR) / BD) % 2;
    e_an = 8'hFF;
    e_seg = 8'hFF;
    if (s > 0 && p > 0) begin
      vis = m_act_en[idx] && !(m_act_bl[idx] && ph);
      if (vis) begin
        e_an  = 8'hFF ^ (8'h01 << idx);
        e_seg = m_act_data[idx*8 +: 8];
      end
    end
    chk("an_n", an_n, e_an);
    chk("seg_n", seg_n, e_seg);
    chk("digit_idx", digit_idx, idx);
    chk("pending", bus.pending, m_pend);
    chk("load_ack", bus.load_ack, m_ack);
  endtask

  task automatic step(input bit ld);
    bus.load = ld;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (bus.load_ack) ack_seen++;
    bus.load = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step(1'b0);
  endtask

  task automatic align(input int r);
    for (int i = 0; i < 2 * FR && (n % FR) != r; i++) step(1'b0);
  endtask

  task automatic set_cfg(input logic [63:0] d, input logic [7:0] en, input logic [7:0] bl);
    bus.disp_data = d;
    bus.dig_en    = en;
    bus.blink_en  = bl;
  endtask

  logic [63:0] seq_data;

  initial begin
    bus.load = 1'b1;
    set_cfg({$urandom, $urandom}, 8'hFF, 8'h00);
    model_reset();

    // 1: reset held with load asserted
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
    bus.load = 1'b0;
    rst_n = 1'b1;

    // 2: bytes 0x10+k, all digits enabled
    for (int k = 0; k < 8; k++) seq_data[8*k +: 8] = 8'h10 + 8'(k);
    run(3);
    set_cfg(seq_data, 8'hFF, 8'h00);
    step(1'b1);
    chk("pending_after_load", bus.pending, 1'b1);
    run(3 * FR);

    // 3: upper four digits disabled
    set_cfg(seq_data, 8'h0F, 8'h00);
    step(1'b1);
    run(2 * FR + 5);

    // 4: digit 0 blinks
    set_cfg(seq_data, 8'hFF, 8'h01);
    step(1'b1);
    run(9 * FR);

    // 5: two loads in one frame, only the second commits
    align(3);
    set_cfg({$urandom, $urandom}, 8'hFF, 8'h00);
    step(1'b1);
    run(7);
    set_cfg({$urandom, $urandom}, 8'hFF, 8'h00);
    ack_seen = 0;
    step(1'b1);
    run(2 * FR);
    chk("single_ack", ack_seen, 1);

    // 6: load C in the commit cycle of staged B
    align(4);
    set_cfg({$urandom, $urandom}, 8'hFF, 8'h00);
    step(1'b1);
    align(FR - 1);
    set_cfg({$urandom, $urandom}, 8'hFF, 8'h00);
    step(1'b1);
    chk("commit_cycle_ack", bus.load_ack, 1'b1);
    chk("commit_cycle_pending", bus.pending, 1'b1);
    run(FR + 10);

    // Reset mid-slot with staged data outstanding
    set_cfg({$urandom, $urandom}, 8'hFF, 8'h00);
    step(1'b1);
    align(2 * TD + 2);
    chk("lit_before_reset", an_n, 8'hFB);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_an_n", an_n, 8'hFF);
    chk("rst_seg_n", seg_n, 8'hFF);
    chk("rst_pending", bus.pending, 1'b0);
    chk("rst_ack", bus.load_ack, 1'b0);
    chk("rst_idx", digit_idx, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2 * FR);

    // Random configurations at random times
    for (int it = 0; it < 10; it++) begin
      set_cfg({$urandom, $urandom}, 8'($urandom), 8'($urandom));
      run($urandom_range(0, 45));
      step(1'b1);
    end
    run(5 * FR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
